// File: rtl/graphics_pkg.sv
// Shared types and constants for the note-lane scheduling logic.
package graphics_pkg;

    localparam int unsigned LANE_W         = 3;
    localparam int unsigned DEFAULT_PERIOD = 818937;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/tick_divider.sv
// Programmable tick divider: counts 0..period_q and emits a registered one-cycle
// tick on each wrap. A config write reloads the period and restarts the count.
module tick_divider #(
    parameter int unsigned PERIOD_W       = 20,
    parameter int unsigned DEFAULT_PERIOD = 818937
) (
    input  logic                in_clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                cfg_we,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                tick
);

    logic [PERIOD_W-1:0] count_q, count_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                tick_q, tick_d;

    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        tick_d   = 1'b0;
        // A config write wins over the increment and swallows a coincident wrap.
        if (cfg_we) begin
            count_d  = '0;
            period_d = cfg_period;
        end else if (enable) begin
            if (count_q == period_q) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            period_q <= PERIOD_W'(DEFAULT_PERIOD);
            tick_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            tick_q   <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/note_step_scheduler.sv
// Per-frame lane sequencer: on each divider tick, walks lanes 0..NUM_LANES-1 with a
// req/ack handshake, queues at most one extra tick and flags any tick beyond that.
module note_step_scheduler #(
    parameter int unsigned PERIOD_W       = 20,
    parameter int unsigned DEFAULT_PERIOD = graphics_pkg::DEFAULT_PERIOD,
    parameter int unsigned NUM_LANES      = 5
) (
    input  logic                              in_clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              cfg_we,
    input  logic [PERIOD_W-1:0]               cfg_period,
    input  logic                              step_ack,
    input  logic                              clr_overrun,
    output logic                              tick,
    output logic                              step_req,
    output logic [graphics_pkg::LANE_W-1:0]   step_lane,
    output logic                              frame_done,
    output logic                              busy,
    output logic                              overrun
);

    import graphics_pkg::*;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    sched_state_t      state_q, state_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              overrun_set;

    tick_divider #(
        .PERIOD_W       (PERIOD_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_tick_divider (
        .in_clk     (in_clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cfg_we     (cfg_we),
        .cfg_period (cfg_period),
        .tick       (tick)
    );

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        pending_d   = pending_q;
        overrun_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick || pending_q) begin
                    state_d   = REQ;
                    lane_d    = '0;
                    // Tick and pending together: one starts now, the other stays queued.
                    pending_d = tick && pending_q;
                end
            end
            REQ: begin
                if (step_ack) begin
                    if (lane_q == LAST_LANE) begin
                        state_d = DONE;
                        lane_d  = '0;
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (tick && (state_q != IDLE)) begin
            if (pending_q) begin
                overrun_set = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        overrun_d = overrun_set || (overrun_q && !clr_overrun);
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign step_req   = (state_q == REQ);
    assign step_lane  = lane_q;
    assign frame_done = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

endmodule
